// File: rtl/lock_sequencer_if.sv
// Request, sensor and actuator bundle between the lock sequencer and its neighbours.
// The master side raises requests and reports occupancy; the slave side is the sequencer.
interface lock_sequencer_if;
    logic arrive;
    logic depart;
    logic occupied;
    logic outer_open;
    logic inner_open;
    logic press_up;
    logic press_down;
    logic chamber_high;
    logic busy;
    logic dir;
    logic abort;

    modport master (
        output arrive, depart, occupied,
        input  outer_open, inner_open, press_up, press_down, chamber_high, busy, dir, abort
    );

    modport slave (
        input  arrive, depart, occupied,
        output outer_open, inner_open, press_up, press_down, chamber_high, busy, dir, abort
    );
endinterface

// File: rtl/lock_sequencer.sv
// Lock chamber controller: arbitrates arrival/departure requests and walks the
// outer port, inner port and pressure pump through one complete transit at a time.
module lock_sequencer #(
    parameter int PRESS_CYCLES = 8,
    parameter int DOOR_CYCLES  = 4,
    parameter int TIMEOUT      = 64
) (
    input  logic            clk,
    input  logic            rst,
    lock_sequencer_if.slave bus
);

    localparam int MAX_PD  = (PRESS_CYCLES > DOOR_CYCLES) ? PRESS_CYCLES : DOOR_CYCLES;
    localparam int MAX_CYC = (MAX_PD > TIMEOUT) ? MAX_PD : TIMEOUT;
    localparam int CW      = $clog2(MAX_CYC + 1);

    localparam logic [CW-1:0] PRESS_LD = CW'(PRESS_CYCLES - 1);
    localparam logic [CW-1:0] DOOR_LD  = CW'(DOOR_CYCLES - 1);
    localparam logic [CW-1:0] WAIT_LD  = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        PREP      = 4'd1,
        OPEN_SRC  = 4'd2,
        WAIT_IN   = 4'd3,
        CLOSE_SRC = 4'd4,
        PUMP      = 4'd5,
        OPEN_DST  = 4'd6,
        WAIT_OUT  = 4'd7,
        CLOSE_DST = 4'd8
    } state_t;

    state_t        state_r;
    state_t        next_state_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_ld_s;
    logic          pend_arr_r;
    logic          pend_dep_r;
    logic          dir_r;
    logic          level_r;
    logic          aborted_r;
    logic          grant_arr_s;
    logic          grant_dep_s;
    logic          level_tgl_s;
    logic          timeout_s;
    logic          cnt_zero_s;
    logic          src_high_s;
    logic          outer_s;
    logic          inner_s;
    logic          up_s;
    logic          down_s;
    logic          outer_r;
    logic          inner_r;
    logic          up_r;
    logic          down_r;
    logic          high_r;
    logic          busy_r;
    logic          dir_out_r;
    logic          abort_r;

    assign cnt_zero_s = (cnt_r == CNT_ZERO);
    // dir_r doubles as last_served; departures start from the high-pressure side.
    assign src_high_s = ~dir_r;

    // State, shared counter, pending request flags and chamber pressure level.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r    <= IDLE;
            cnt_r      <= CNT_ZERO;
            pend_arr_r <= 1'b0;
            pend_dep_r <= 1'b0;
            dir_r      <= 1'b0;
            level_r    <= 1'b0;
            aborted_r  <= 1'b0;
        end else begin
            state_r <= next_state_s;
            if (next_state_s != state_r) begin
                cnt_r <= cnt_ld_s;
            end else if (!cnt_zero_s) begin
                cnt_r <= cnt_r - CNT_ONE;
            end
            pend_arr_r <= grant_arr_s ? 1'b0 : (pend_arr_r | bus.arrive);
            pend_dep_r <= grant_dep_s ? 1'b0 : (pend_dep_r | bus.depart);
            if (grant_arr_s || grant_dep_s) begin
                dir_r     <= grant_arr_s;
                aborted_r <= 1'b0;
            end else if (timeout_s && (state_r == WAIT_IN)) begin
                aborted_r <= 1'b1;
            end
            if (level_tgl_s) begin
                level_r <= ~level_r;
            end
        end
    end

    // Next-state selection, arbitration and counter load value for the entered state.
    always_comb begin
        next_state_s = state_r;
        grant_arr_s  = 1'b0;
        grant_dep_s  = 1'b0;
        level_tgl_s  = 1'b0;
        timeout_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (pend_arr_r && (!pend_dep_r || !dir_r)) begin
                    grant_arr_s  = 1'b1;
                    next_state_s = PREP;
                end else if (pend_dep_r) begin
                    grant_dep_s  = 1'b1;
                    next_state_s = PREP;
                end else begin
                    next_state_s = IDLE;
                end
            end
            PREP: begin
                if (level_r == src_high_s) begin
                    next_state_s = OPEN_SRC;
                end else if (cnt_zero_s) begin
                    level_tgl_s  = 1'b1;
                    next_state_s = OPEN_SRC;
                end else begin
                    next_state_s = PREP;
                end
            end
            OPEN_SRC: next_state_s = cnt_zero_s ? WAIT_IN : OPEN_SRC;
            WAIT_IN: begin
                if (bus.occupied) begin
                    next_state_s = CLOSE_SRC;
                end else if (cnt_zero_s) begin
                    timeout_s    = 1'b1;
                    next_state_s = CLOSE_SRC;
                end else begin
                    next_state_s = WAIT_IN;
                end
            end
            CLOSE_SRC: begin
                if (cnt_zero_s) begin
                    next_state_s = aborted_r ? IDLE : PUMP;
                end else begin
                    next_state_s = CLOSE_SRC;
                end
            end
            PUMP: begin
                if (cnt_zero_s) begin
                    level_tgl_s  = 1'b1;
                    next_state_s = OPEN_DST;
                end else begin
                    next_state_s = PUMP;
                end
            end
            OPEN_DST: next_state_s = cnt_zero_s ? WAIT_OUT : OPEN_DST;
            WAIT_OUT: begin
                if (!bus.occupied) begin
                    next_state_s = CLOSE_DST;
                end else if (cnt_zero_s) begin
                    timeout_s    = 1'b1;
                    next_state_s = CLOSE_DST;
                end else begin
                    next_state_s = WAIT_OUT;
                end
            end
            CLOSE_DST: next_state_s = cnt_zero_s ? IDLE : CLOSE_DST;
            default:   next_state_s = IDLE;
        endcase

        case (next_state_s)
            PREP, PUMP:                              cnt_ld_s = PRESS_LD;
            OPEN_SRC, CLOSE_SRC, OPEN_DST, CLOSE_DST: cnt_ld_s = DOOR_LD;
            WAIT_IN, WAIT_OUT:                       cnt_ld_s = WAIT_LD;
            default:                                 cnt_ld_s = CNT_ZERO;
        endcase
    end

    // Actuator decode; each state drives at most one port or one pump direction.
    always_comb begin
        outer_s = 1'b0;
        inner_s = 1'b0;
        up_s    = 1'b0;
        down_s  = 1'b0;
        case (state_r)
            PREP: begin
                if (level_r != src_high_s) begin
                    up_s   = src_high_s;
                    down_s = ~src_high_s;
                end else begin
                    up_s   = 1'b0;
                    down_s = 1'b0;
                end
            end
            OPEN_SRC, WAIT_IN: begin
                outer_s = dir_r;
                inner_s = ~dir_r;
            end
            PUMP: begin
                up_s   = dir_r;
                down_s = ~dir_r;
            end
            OPEN_DST, WAIT_OUT: begin
                outer_s = ~dir_r;
                inner_s = dir_r;
            end
            default: begin
                outer_s = 1'b0;
                inner_s = 1'b0;
            end
        endcase
    end

    // Output registers: every actuator and status line is a flop.
    always_ff @(posedge clk) begin
        if (!rst) begin
            outer_r   <= 1'b0;
            inner_r   <= 1'b0;
            up_r      <= 1'b0;
            down_r    <= 1'b0;
            high_r    <= 1'b0;
            busy_r    <= 1'b0;
            dir_out_r <= 1'b0;
            abort_r   <= 1'b0;
        end else begin
            outer_r   <= outer_s;
            inner_r   <= inner_s;
            up_r      <= up_s;
            down_r    <= down_s;
            high_r    <= level_r;
            busy_r    <= (state_r != IDLE);
            dir_out_r <= dir_r;
            abort_r   <= timeout_s;
        end
    end

    assign bus.outer_open   = outer_r;
    assign bus.inner_open   = inner_r;
    assign bus.press_up     = up_r;
    assign bus.press_down   = down_r;
    assign bus.chamber_high = high_r;
    assign bus.busy         = busy_r;
    assign bus.dir          = dir_out_r;
    assign bus.abort        = abort_r;

endmodule

// File: tb/tb_lock_sequencer.sv
// Scoreboard bench for lock_sequencer: a transit summary is queued when a request is
// driven and compared against the observed actuator activity when the transit ends.
module tb_lock_sequencer;

    localparam int P = 4;
    localparam int D = 2;
    localparam int T = 10;

    logic clk = 1'b0;
    logic rst = 1'b0;

    lock_sequencer_if bus ();

    lock_sequencer #(.PRESS_CYCLES(P), .DOOR_CYCLES(D), .TIMEOUT(T)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic d;
        int   up;
        int   down;
        int   aborts;
        int   outer;
        int   inner;
        logic high;
        int   first;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks  = 0;
    int   n_pass    = 0;
    int   done_cnt  = 0;
    int   last_gap  = 0;
    int   resp_mode = 0;
    bit   sb_en     = 1'b1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic expect_transit(input logic d, input int up, input int down, input int aborts,
                                  input int outer, input int inner, input logic high, input int first);
        exp_t e;
        e.d = d; e.up = up; e.down = down; e.aborts = aborts;
        e.outer = outer; e.inner = inner; e.high = high; e.first = first;
        sb_q.push_back(e);
    endtask

    task automatic check_quiet(input string pfx);
        check_val({pfx, "_outer_open"},   32'(bus.outer_open),   32'd0);
        check_val({pfx, "_inner_open"},   32'(bus.inner_open),   32'd0);
        check_val({pfx, "_press_up"},     32'(bus.press_up),     32'd0);
        check_val({pfx, "_press_down"},   32'(bus.press_down),   32'd0);
        check_val({pfx, "_chamber_high"}, 32'(bus.chamber_high), 32'd0);
        check_val({pfx, "_busy"},         32'(bus.busy),         32'd0);
        check_val({pfx, "_dir"},          32'(bus.dir),          32'd0);
        check_val({pfx, "_abort"},        32'(bus.abort),        32'd0);
    endtask

    task automatic wait_done(input int target, input int budget);
        int i = 0;
        while (done_cnt < target && i < budget) begin
            @(negedge clk);
            i++;
        end
        check_val("transit_done", 32'(done_cnt), 32'(target));
    endtask

    task automatic pulse(input bit a, input bit d);
        @(posedge clk); #1;
        bus.arrive = a;
        bus.depart = d;
        @(posedge clk); #1;
        bus.arrive = 1'b0;
        bus.depart = 1'b0;
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // Craft model: enters when the source port opens, leaves when the destination opens.
    initial begin
        bus.occupied = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (resp_mode)
                0: begin
                    if ((bus.outer_open && bus.dir) || (bus.inner_open && !bus.dir)) begin
                        bus.occupied = 1'b1;
                    end else if ((bus.inner_open && bus.dir) || (bus.outer_open && !bus.dir)) begin
                        bus.occupied = 1'b0;
                    end
                end
                1:       bus.occupied = 1'b0;
                default: bus.occupied = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: invariants every cycle, per-transit activity tally, scoreboard pop at busy fall.
    initial begin
        int   c_up, c_dn, c_ab, c_out, c_in, first, idle_run;
        logic prev_busy;
        exp_t e;
        c_up = 0; c_dn = 0; c_ab = 0; c_out = 0; c_in = 0; first = 0; idle_run = 0;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                sb_q.delete();
                c_up = 0; c_dn = 0; c_ab = 0; c_out = 0; c_in = 0; first = 0;
                prev_busy = 1'b0;
            end else begin
                check_val("ports_exclusive", 32'(bus.outer_open & bus.inner_open), 32'd0);
                check_val("pump_exclusive", 32'(bus.press_up & bus.press_down), 32'd0);
                check_val("pump_with_port",
                          32'((bus.press_up | bus.press_down) & (bus.outer_open | bus.inner_open)), 32'd0);
                if (bus.press_up)   c_up++;
                if (bus.press_down) c_dn++;
                if (bus.abort)      c_ab++;
                if (bus.outer_open) c_out++;
                if (bus.inner_open) c_in++;
                if (first == 0 && bus.outer_open) first = 1;
                if (first == 0 && bus.inner_open) first = 2;
                if (bus.busy) begin
                    if (!prev_busy) last_gap = idle_run;
                    idle_run = 0;
                end else begin
                    idle_run++;
                end
                if (prev_busy && !bus.busy) begin
                    if (sb_en) begin
                        check_val("sb_has_entry", 32'(sb_q.size() > 0), 32'd1);
                        if (sb_q.size() > 0) begin
                            e = sb_q.pop_front();
                            check_val("sb_dir",          32'(bus.dir),          32'(e.d));
                            check_val("sb_press_up",     32'(c_up),             32'(e.up));
                            check_val("sb_press_down",   32'(c_dn),             32'(e.down));
                            check_val("sb_abort",        32'(c_ab),             32'(e.aborts));
                            check_val("sb_outer_cycles", 32'(c_out),            32'(e.outer));
                            check_val("sb_inner_cycles", 32'(c_in),             32'(e.inner));
                            check_val("sb_chamber_high", 32'(bus.chamber_high), 32'(e.high));
                            check_val("sb_first_port",   32'(first),            32'(e.first));
                        end
                    end
                    done_cnt++;
                    c_up = 0; c_dn = 0; c_ab = 0; c_out = 0; c_in = 0; first = 0;
                end
                prev_busy = bus.busy;
            end
        end
    end

    initial begin
        int guard;
        bus.arrive = 1'b0;
        bus.depart = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_quiet("reset");
        @(posedge clk); #1;
        rst = 1'b1;

        // Arrival from a low chamber, with exact grant-to-open latency.
        expect_transit(1'b1, P, 0, 0, D + 1, D + 1, 1'b1, 1);
        @(posedge clk); #1; bus.arrive = 1'b1;
        @(posedge clk); #1; bus.arrive = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_val("busy_grant_cycle", 32'(bus.busy), 32'd0);
        @(negedge clk);
        check_val("busy_after_grant", 32'(bus.busy), 32'd1);
        check_val("no_prep_pump", 32'(bus.press_up), 32'd0);
        check_val("outer_not_yet", 32'(bus.outer_open), 32'd0);
        @(negedge clk);
        check_val("outer_open_rise", 32'(bus.outer_open), 32'd1);
        wait_done(1, 200);

        // Departure from the now-high chamber: no prep pump, inner side first.
        expect_transit(1'b0, 0, P, 0, D + 1, D + 1, 1'b0, 2);
        pulse(1'b0, 1'b1);
        wait_done(2, 200);

        // Simultaneous requests after reset: arrival then departure back to back.
        apply_reset();
        expect_transit(1'b1, P, 0, 0, D + 1, D + 1, 1'b1, 1);
        expect_transit(1'b0, 0, P, 0, D + 1, D + 1, 1'b0, 2);
        pulse(1'b1, 1'b1);
        wait_done(4, 400);
        check_val("back_to_back_gap", 32'(last_gap), 32'd1);

        // No craft ever enters: single abort, outer closes, no pumping.
        resp_mode = 1;
        expect_transit(1'b1, 0, 0, 1, D + T, 0, 1'b0, 1);
        pulse(1'b1, 1'b0);
        wait_done(5, 200);
        check_val("sb_drained", 32'(sb_q.size()), 32'd0);

        // Reset during the transfer pump with a departure still pending.
        resp_mode = 0;
        @(posedge clk); #1; bus.arrive = 1'b1;
        @(posedge clk); #1; bus.arrive = 1'b0; bus.depart = 1'b1;
        @(posedge clk); #1; bus.depart = 1'b0;
        guard = 0;
        while (bus.press_up !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check_val("pump_reached", 32'(bus.press_up), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_quiet("midrst");
        resp_mode = 1;
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (12) @(negedge clk);
        check_val("pending_cleared_busy", 32'(bus.busy), 32'd0);
        check_val("pending_cleared_high", 32'(bus.chamber_high), 32'd0);

        // Random stress: invariants only.
        sb_en = 1'b0;
        resp_mode = 2;
        for (int i = 0; i < 10000; i++) begin
            @(posedge clk); #1;
            bus.arrive = ($urandom_range(0, 19) == 0);
            bus.depart = ($urandom_range(0, 19) == 0);
        end
        bus.arrive = 1'b0;
        bus.depart = 1'b0;
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/lock_sequencer.md
Name: lock_sequencer

Overview:
- Central controller for the lock chamber between the outer (low-pressure) and inner (high-pressure) sides.
- Takes the registered arrival/departure request levels and the chamber occupancy sensor.
- Arbitrates between pending arrival and departure requests, then sequences the outer port, inner port and pressure pump through a complete transit.
- Sits directly downstream of the arrival/departure signal registers and drives the port and pump actuators.

Parameters:
PRESS_CYCLES, 8, cycles press_up/press_down held to move chamber between pressure levels (>=1)
DOOR_CYCLES, 4, cycles a port takes to open or close (>=1)
TIMEOUT, 64, cycles a port stays fully open waiting for occupancy change before abort (>=1)

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-low
arrive  input  1  registered arrival request level
depart  input  1  registered departure request level
occupied  input  1  chamber occupancy sensor, 1 = craft in chamber
outer_open  output  1  command outer port open
inner_open  output  1  command inner port open
press_up  output  1  pump chamber toward inner pressure
press_down  output  1  vent chamber toward outer pressure
chamber_high  output  1  chamber currently at inner pressure
busy  output  1  transit in progress (state != IDLE)
dir  output  1  current/last transit direction, 1 = arrival, 0 = departure
abort  output  1  one-cycle pulse on timeout abort

Behaviour:
- Reset (clk edge with rst=0), any state: state=IDLE, all outputs 0, pending_arr=pending_dep=0, last_served=departure, counter=0. Mid-transit reset drops both ports and the pump on the next edge.
- Request capture, every cycle: pending_arr set when arrive=1, pending_dep set when depart=1. Each flag is cleared only when its transit is granted. Requests arriving while busy stay pending.
- Arbitration, IDLE only: exactly one flag pending -> grant it. Both pending -> grant the direction opposite last_served, so the first grant after reset is arrival. Grant sets dir, clears that flag, updates last_served, and goes to PREP. Grant happens on the cycle after the flag sets.
- Source side: outer for arrival, inner for departure. Destination is the other side.
- Source pressure level: low (chamber_high=0) for arrival, high for departure.
- PREP: chamber already at source level -> OPEN_SRC next cycle. Otherwise assert press_up or press_down for PRESS_CYCLES cycles, toggle chamber_high on the last one, then go to OPEN_SRC.
- OPEN_SRC: source open output = 1. Hold DOOR_CYCLES, then WAIT_IN.
- WAIT_IN: source port stays open. occupied=1 -> CLOSE_SRC. If TIMEOUT cycles elapse with occupied=0, pulse abort for 1 cycle, go to CLOSE_SRC, and the sequence ends in IDLE after the close.
- CLOSE_SRC: open output = 0. Hold DOOR_CYCLES, then PUMP (normal) or IDLE (abort).
- PUMP: drive the chamber to the destination level for PRESS_CYCLES cycles. chamber_high toggles on the last cycle.
- OPEN_DST: hold DOOR_CYCLES with the destination open output = 1.
- WAIT_OUT: destination port stays open. occupied=0 -> CLOSE_DST. On timeout, pulse abort and close anyway; the craft is logged as stuck.
- CLOSE_DST: hold DOOR_CYCLES, then IDLE.
- Invariants, always:
  - outer_open and inner_open never both 1.
  - press_up and press_down never both 1.
  - No pump output while either port is open.
- Counter: one shared down-counter, width $clog2(max(PRESS_CYCLES,DOOR_CYCLES,TIMEOUT)+1). Loaded on every state entry, saturates at 0.
- All outputs are registered (Moore). Outputs change one cycle after the state transition edge.
- Nominal latency, grant to IDLE with chamber pre-set, excluding sensor waits: 4*DOOR_CYCLES + PRESS_CYCLES + WAIT times + state overhead (1 cycle per state).

Test Plan:
- Reset, then arrive=1 one cycle, PRESS=4, DOOR=2: outer_open rises after grant and stays 2 cycles before WAIT_IN; occupied=1 -> outer closes; press_up 4 cycles; chamber_high=1; inner_open; occupied=0 -> inner closes; busy=0.
- After the arrival above, depart=1: no PREP pump (chamber already high); inner opens first; press_down 4 cycles; outer opens; chamber_high ends 0.
- arrive=1 and depart=1 same cycle after reset: arrival served first, departure served immediately after, dir toggles 1 then 0.
- Arrival with occupied held 0, TIMEOUT=10: abort pulses exactly once after 10 WAIT_IN cycles; outer closes; no pump activity; returns to IDLE with chamber_high=0.
- rst=0 asserted mid-PUMP: next edge all outputs 0 and state IDLE; pending requests cleared.
- Random request/occupied stress over 10k cycles: assertions that both ports are never open together, never pump with a port open, and press_up/press_down are never both high.
